// File: rtl/alu_issue.sv
// Issue stage: decodes an RV32 subset into an ALU op code and operands, held in a 1-deep skid-free register.
// Optional operand forwarding from writeback is built when ALU_ISSUE_FWD_EN is defined.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr_in,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
`ifdef ALU_ISSUE_FWD_EN
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [31:0] instruction,
    output logic [5:0]  alu_ctr,
    output logic        illegal
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op1, op2, imm_i, shamt;
    logic [5:0]  dec_ctr;
    logic        dec_ill;
    logic [31:0] dec_d1, dec_d2;
    logic        capture;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];
    assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
    assign shamt  = {27'd0, instr_in[24:20]};

`ifdef ALU_ISSUE_FWD_EN
    // x0 never forwards; a writeback to rd beats the stale register-file read
    assign op1 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr_in[19:15]) ? wb_data : rs1_data;
    assign op2 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr_in[24:20]) ? wb_data : rs2_data;
`else
    assign op1 = rs1_data;
    assign op2 = rs2_data;
`endif

    always_comb begin
        dec_ctr = 6'd0;
        dec_ill = 1'b1;
        dec_d1  = 32'd0;
        dec_d2  = 32'd0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: dec_ctr = 6'd1;
                        3'b001: dec_ctr = 6'd3;
                        3'b101: dec_ctr = 6'd4;
                        3'b010: dec_ctr = 6'd5;
                        3'b100: dec_ctr = 6'd6;
                        3'b110: dec_ctr = 6'd7;
                        3'b111: dec_ctr = 6'd8;
                        default: dec_ctr = 6'd0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_ctr = 6'd2;
                end
                if (dec_ctr != 6'd0) begin
                    dec_ill = 1'b0;
                    dec_d1  = op1;
                    dec_d2  = op2;
                end
            end
            7'b0010011: begin
                case (funct3)
                    3'b000: dec_ctr = 6'd9;
                    3'b100: dec_ctr = 6'd10;
                    3'b110: dec_ctr = 6'd11;
                    3'b111: dec_ctr = 6'd12;
                    3'b001: dec_ctr = (funct7 == 7'b0000000) ? 6'd13 : 6'd0;
                    3'b101: dec_ctr = (funct7 == 7'b0000000) ? 6'd14 : 6'd0;
                    default: dec_ctr = 6'd0;
                endcase
                if (dec_ctr != 6'd0) begin
                    dec_ill = 1'b0;
                    dec_d1  = op1;
                    dec_d2  = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
                end
            end
            7'b0000011: if (funct3 == 3'b010) begin
                dec_ctr = 6'd15; dec_ill = 1'b0; dec_d1 = op1; dec_d2 = imm_i;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                dec_ctr = 6'd16; dec_ill = 1'b0; dec_d1 = op1; dec_d2 = op2;
            end
            7'b1100011: if (funct3 == 3'b000) begin
                dec_ctr = 6'd17; dec_ill = 1'b0; dec_d1 = op1; dec_d2 = op2;
            end
            7'b0110111: begin
                dec_ctr = 6'd18; dec_ill = 1'b0;
            end
            default: ;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            data1       <= 32'd0;
            data2       <= 32'd0;
            instruction <= 32'd0;
            alu_ctr     <= 6'd0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            data1       <= dec_d1;
            data2       <= dec_d2;
            instruction <= instr_in;
            alu_ctr     <= dec_ctr;
            illegal     <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode table, backpressure, flush, async reset, optional forwarding.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [31:0] instr_in, rs1_data, rs2_data, data1, data2, instruction;
    logic [5:0]  alu_ctr;
`ifdef ALU_ISSUE_FWD_EN
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
`ifdef ALU_ISSUE_FWD_EN
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .data1(data1), .data2(data2),
        .instruction(instruction), .alu_ctr(alu_ctr), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bundle(input string tag, input logic v, input logic [5:0] c, input logic il,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] ins);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".ctr"}, {26'd0, alu_ctr}, {26'd0, c});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, il});
        chk({tag, ".data1"}, data1, d1);
        chk({tag, ".data2"}, data2, d2);
        chk({tag, ".instr"}, instruction, ins);
    endtask

    // instr, rs1, rs2, expected ctr, illegal, data1, data2
    typedef struct {
        logic [31:0] ins; logic [31:0] r1; logic [31:0] r2;
        logic [5:0] c; logic il; logic [31:0] d1; logic [31:0] d2;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{32'h402081B3, 32'd9,  32'd4,  6'd2,  1'b0, 32'd9,  32'd4};
        tbl[1] = '{32'h0020E1B3, 32'h0F, 32'hF0, 6'd7,  1'b0, 32'h0F, 32'hF0};
        tbl[2] = '{32'h0020F1B3, 32'h3C, 32'h0F, 6'd8,  1'b0, 32'h3C, 32'h0F};
        tbl[3] = '{32'h0030D093, 32'h80, 32'd1,  6'd14, 1'b0, 32'h80, 32'd3};
        tbl[4] = '{32'hFFC0A083, 32'h100,32'd1,  6'd15, 1'b0, 32'h100,32'hFFFFFFFC};
        tbl[5] = '{32'h0020A423, 32'h20, 32'h55, 6'd16, 1'b0, 32'h20, 32'h55};
        tbl[6] = '{32'h00208063, 32'd1,  32'd2,  6'd17, 1'b0, 32'd1,  32'd2};
        tbl[7] = '{32'h123450B7, 32'd7,  32'd8,  6'd18, 1'b0, 32'd0,  32'd0};
        tbl[8] = '{32'h40309093, 32'd7,  32'd8,  6'd0,  1'b1, 32'd0,  32'd0};
        tbl[9] = '{32'h00000000, 32'd7,  32'd8,  6'd0,  1'b1, 32'd0,  32'd0};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr_in = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        #12;
        chk_bundle("reset", 1'b0, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();

        // add x3,x1,x2
        in_valid = 1'b1; instr_in = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        #1 chk("add.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_bundle("add", 1'b1, 6'd1, 1'b0, 32'd5, 32'd7, 32'h002081B3);

        instr_in = 32'hFFF00093; rs1_data = 32'd0;
        tick();
        chk_bundle("addi", 1'b1, 6'd9, 1'b0, 32'd0, 32'hFFFFFFFF, 32'hFFF00093);
        instr_in = 32'h00309093; rs1_data = 32'hFFFFFFFF;
        tick();
        chk_bundle("slli", 1'b1, 6'd13, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h00309093);

        // backpressure: held bundle stable, next one lands right after release
        out_ready = 1'b0; instr_in = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd4;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk_bundle("bp.hold", 1'b1, 6'd13, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h00309093);
        end
        out_ready = 1'b1;
        #1 chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_bundle("bp.next", 1'b1, 6'd2, 1'b0, 32'd9, 32'd4, 32'h402081B3);

        for (int i = 0; i < 10; i++) begin
            instr_in = tbl[i].ins; rs1_data = tbl[i].r1; rs2_data = tbl[i].r2;
            tick();
            chk_bundle($sformatf("tbl%0d", i), 1'b1, tbl[i].c, tbl[i].il, tbl[i].d1, tbl[i].d2, tbl[i].ins);
        end

        // flush beats the incoming capture
        out_ready = 1'b0; flush = 1'b1; instr_in = 32'h002081B3;
        tick();
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush.idle", {31'd0, out_valid}, 32'd0);

        // drain without refill
        in_valid = 1'b1; rs1_data = 32'd5; rs2_data = 32'd7;
        tick();
        chk("drain.cap", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("drain.empty", {31'd0, out_valid}, 32'd0);

        // async reset mid-cycle with a held bundle
        in_valid = 1'b1;
        tick();
        chk("rst.pre", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_bundle("rst.async", 1'b0, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk_bundle("rst.first", 1'b1, 6'd1, 1'b0, 32'd5, 32'd7, 32'h002081B3);

`ifdef ALU_ISSUE_FWD_EN
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h10;
        tick();
        chk("fwd.hit", data1, 32'h10);
        chk("fwd.rs2", data2, 32'd7);
        wb_rd = 5'd0;
        tick();
        chk("fwd.x0", data1, 32'd5);
        wb_valid = 1'b0;
`endif
        in_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
